// File: rtl/fifo_arb_pkg.sv
// ----------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared types and helpers for the round-robin front-end arbiters.
//   - clog2    : ceiling log2, used to size source-ID and pointer fields.
//   - rr_pick  : rotating-priority search over a request vector of up to
//                RR_MAX_REQ bits; returns the first set index at or after
//                ptr (wrapping modulo n) plus a found flag.
// ----------------------------------------------------------------------------
package fifo_arb_pkg;

  localparam int RR_MAX_REQ = 16;
  localparam int RR_IDX_W   = 4;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Scans ptr, ptr+1, ... wrapping at n. Callers keep ptr < n and n in 2..16.
  // The loop bound is the fixed maximum so it unrolls to a static mux tree.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                       input logic [RR_IDX_W-1:0]   ptr,
                                       input int unsigned           n);
    rr_pick_t            r;
    logic [RR_IDX_W-1:0] k;
    r.found = 1'b0;
    r.idx   = '0;
    for (int unsigned off = 0; off < RR_MAX_REQ; off++) begin
      if (off < n && !r.found) begin
        k = RR_IDX_W'((32'(ptr) + off) % n);
        if (req[k]) begin
          r.found = 1'b1;
          r.idx   = k;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo1_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// fifo1_rr_arbiter_if
//   Producer-side request/grant bundle plus consumer-side dequeue bundle of
//   the shared one-entry arbiter stage.
//   Producer side : REQ_VALID, REQ_DATA (payload i at [i*width +: width]),
//                   REQ_GRANT (one-hot or zero, combinational).
//   Consumer side : CLR, DEQ, EMPTY_N, D_OUT, D_OUT_ID (all outputs registered).
//   master = the producers/consumer environment, slave = the arbiter.
// ----------------------------------------------------------------------------
interface fifo1_rr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int n_req = 4,
  parameter int width = 8
) ();

  localparam int idw = clog2(n_req);

  logic [n_req-1:0]       REQ_VALID;
  logic [n_req*width-1:0] REQ_DATA;
  logic [n_req-1:0]       REQ_GRANT;
  logic                   CLR;
  logic                   DEQ;
  logic                   EMPTY_N;
  logic [width-1:0]       D_OUT;
  logic [idw-1:0]         D_OUT_ID;

  modport master (
    output REQ_VALID, REQ_DATA, CLR, DEQ,
    input  REQ_GRANT, EMPTY_N, D_OUT, D_OUT_ID
  );

  modport slave (
    input  REQ_VALID, REQ_DATA, CLR, DEQ,
    output REQ_GRANT, EMPTY_N, D_OUT, D_OUT_ID
  );

endinterface

// File: rtl/rr_pick_n.sv
// ----------------------------------------------------------------------------
// rr_pick_n
//   Purely combinational rotating priority encoder, reusable by any arbiter.
//   Ports:
//     req_i    [n_req]  request vector
//     ptr_i    [idw]    highest-priority index (must be < n_req)
//     onehot_o [n_req]  one-hot winner, zero if no request
//     idx_o    [idw]    winner index (0 when none)
//     any_o             at least one request present
// ----------------------------------------------------------------------------
module rr_pick_n
  import fifo_arb_pkg::*;
#(
  parameter int n_req = 4,
  parameter int idw   = clog2(n_req)
) (
  input  logic [n_req-1:0] req_i,
  input  logic [idw-1:0]   ptr_i,
  output logic [n_req-1:0] onehot_o,
  output logic [idw-1:0]   idx_o,
  output logic             any_o
);

  logic [RR_MAX_REQ-1:0] req_ext;
  rr_pick_t              pick;

  always_comb begin
    req_ext             = '0;
    req_ext[n_req-1:0]  = req_i;
    pick                = rr_pick(req_ext, RR_IDX_W'(ptr_i), n_req);
    onehot_o            = '0;
    if (pick.found) onehot_o[pick.idx[idw-1:0]] = 1'b1;
    idx_o               = pick.idx[idw-1:0];
    any_o               = pick.found;
  end

  // Upper index bits are always zero for n_req < 16; fold them away.
  logic unused_pick;
  assign unused_pick = ^pick;

endmodule

// File: rtl/fifo1_rr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo1_rr_arbiter
//   One-entry holding register shared by n_req producers. A rotating-priority
//   arbiter admits at most one producer per cycle whenever the entry is free
//   or being dequeued in the same cycle, giving one item per cycle throughput.
//   Ports:
//     CLK  clock, all state on posedge
//     RST  synchronous active-high reset; also masks REQ_GRANT while high
//     bus  fifo1_rr_arbiter_if.slave (request/grant and consumer bundles)
//   Parameters:
//     n_req   number of producers (2..16)
//     width   payload width
//     guarded nonzero: simulation warns on DEQ while empty
// ----------------------------------------------------------------------------
module fifo1_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int n_req   = 4,
  parameter int width   = 8,
  parameter int guarded = 1
) (
  input logic                CLK,
  input logic                RST,
  fifo1_rr_arbiter_if.slave  bus
);

  localparam int idw = clog2(n_req);

  logic             full_q,  full_d;
  logic [idw-1:0]   ptr_q,   ptr_d;
  logic [width-1:0] data_q,  data_d;
  logic [idw-1:0]   id_q,    id_d;

  logic [n_req-1:0] pick_onehot;
  logic [idw-1:0]   pick_idx;
  logic             pick_any;
  logic             accept_ok;
  logic             grant_en;
  logic             grant;

  rr_pick_n #(
    .n_req (n_req),
    .idw   (idw)
  ) u_pick (
    .req_i    (bus.REQ_VALID),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // A dequeue in the same cycle frees the slot, so a full entry can still
  // accept. CLR and RST both suppress the grant for that cycle.
  assign accept_ok = !full_q || bus.DEQ;
  assign grant_en  = accept_ok && !bus.CLR && !RST;
  assign grant     = grant_en && pick_any;

  assign bus.REQ_GRANT = grant_en ? pick_onehot : '0;

  always_comb begin
    full_d = full_q;
    ptr_d  = ptr_q;
    data_d = data_q;
    id_d   = id_q;
    if (bus.CLR) begin
      // Flush only; pointer keeps its place and DEQ is ignored.
      full_d = 1'b0;
    end else if (grant) begin
      full_d = 1'b1;
      data_d = bus.REQ_DATA[pick_idx*width +: width];
      id_d   = pick_idx;
      ptr_d  = (pick_idx == idw'(n_req - 1)) ? '0 : pick_idx + 1'b1;
    end else if (bus.DEQ) begin
      // Payload and ID left stale; only the valid flag drops.
      full_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      full_q <= 1'b0;
      ptr_q  <= '0;
      data_q <= '0;
      id_q   <= '0;
    end else begin
      full_q <= full_d;
      ptr_q  <= ptr_d;
      data_q <= data_d;
      id_q   <= id_d;
    end
  end

  assign bus.EMPTY_N  = full_q;
  assign bus.D_OUT    = data_q;
  assign bus.D_OUT_ID = id_q;

`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if (guarded != 0 && !RST && !bus.CLR && bus.DEQ && !full_q)
      $warning("fifo1_rr_arbiter: DEQ on empty");
  end
`endif

endmodule

// File: tb/tb_fifo1_rr_arbiter.sv
module tb_fifo1_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  fifo1_rr_arbiter_if #(.n_req(N), .width(W)) bus ();

  fifo1_rr_arbiter #(.n_req(N), .width(W), .guarded(1)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: remembers who was served last; the next search
  // starts just after that producer.
  bit         m_known = 1'b0;
  bit         m_full  = 1'b0;
  logic [7:0] m_data  = '0;
  int         m_id    = 0;
  int         m_last  = N - 1;
  logic [3:0] m_g     = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [3:0] model_grant();
    if (rst || bus.CLR || (m_full && !bus.DEQ)) return 4'b0000;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (bus.REQ_VALID[i]) return 4'(1 << i);
    end
    return 4'b0000;
  endfunction

  always @(posedge clk) begin
    logic [3:0] g;
    g   = model_grant();
    m_g = g;
    if (rst) begin
      m_known = 1'b1;
      m_full  = 1'b0;
      m_last  = N - 1;
      m_data  = '0;
      m_id    = 0;
    end else if (m_known) begin
      if (bus.CLR) begin
        m_full = 1'b0;
      end else if (g != 4'b0000) begin
        for (int i = 0; i < N; i++) if (g[i]) m_id = i;
        m_data = bus.REQ_DATA[m_id*W +: W];
        m_last = m_id;
        m_full = 1'b1;
      end else if (bus.DEQ) begin
        m_full = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("grant", 32'(bus.REQ_GRANT), 32'(model_grant()));
      chk("empty_n", 32'(bus.EMPTY_N), 32'(m_full));
      if (m_full) begin
        chk("d_out", 32'(bus.D_OUT), 32'(m_data));
        chk("d_out_id", 32'(bus.D_OUT_ID), 32'(m_id));
      end
    end
  end

  task automatic to_mid();
    @(negedge clk);
    #1;
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.REQ_VALID = 4'b1111;
    bus.REQ_DATA  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.DEQ       = 1'b0;
    bus.CLR       = 1'b0;

    // Reset: grant masked throughout.
    repeat (2) begin
      to_mid();
      chk("rst_grant", 32'(bus.REQ_GRANT), 32'h0);
      to_next();
    end
    rst     = 1'b0;
    bus.DEQ = 1'b1;
    to_mid();
    chk("first_empty_n", 32'(bus.EMPTY_N), 32'h0);
    chk("first_grant", 32'(bus.REQ_GRANT), 32'h1);
    to_next();

    // Rotation with DEQ every cycle.
    for (int k = 0; k < 4; k++) begin
      to_mid();
      chk("rot_dout", 32'(bus.D_OUT), 32'(8'hA0 + k));
      chk("rot_id", 32'(bus.D_OUT_ID), 32'(k));
      chk("rot_empty_n", 32'(bus.EMPTY_N), 32'h1);
      chk("rot_grant", 32'(bus.REQ_GRANT), 32'(1 << ((k + 1) % 4)));
      to_next();
    end

    // Backpressure: held A0, pointer at 1.
    bus.DEQ       = 1'b0;
    bus.REQ_VALID = 4'b0110;
    to_mid();
    chk("rot_dout5", 32'(bus.D_OUT), 32'hA0);
    chk("rot_id5", 32'(bus.D_OUT_ID), 32'h0);
    chk("bp_grant", 32'(bus.REQ_GRANT), 32'h0);
    to_next();
    to_mid();
    chk("bp_hold", 32'(bus.D_OUT), 32'hA0);
    chk("bp_grant2", 32'(bus.REQ_GRANT), 32'h0);
    bus.DEQ = 1'b1;
    #1;
    chk("bp_release", 32'(bus.REQ_GRANT), 32'b0010);
    to_next();
    bus.REQ_VALID = 4'b0100;
    to_mid();
    chk("bp_id", 32'(bus.D_OUT_ID), 32'h1);
    chk("bp_dout", 32'(bus.D_OUT), 32'hA1);
    chk("to_ptr3_grant", 32'(bus.REQ_GRANT), 32'b0100);
    to_next();

    // Wrap and skip from pointer 3.
    bus.REQ_VALID = 4'b0101;
    to_mid();
    chk("wrap_grant", 32'(bus.REQ_GRANT), 32'b0001);
    chk("wrap_id", 32'(bus.D_OUT_ID), 32'h2);
    to_next();
    to_mid();
    chk("skip_grant", 32'(bus.REQ_GRANT), 32'b0100);
    chk("skip_id", 32'(bus.D_OUT_ID), 32'h0);
    to_next();

    // CLR while full, pointer at 3.
    bus.REQ_VALID = 4'b1000;
    bus.CLR       = 1'b1;
    bus.DEQ       = 1'b1;
    to_mid();
    chk("clr_grant", 32'(bus.REQ_GRANT), 32'h0);
    to_next();
    bus.CLR       = 1'b0;
    bus.REQ_VALID = 4'b1001;
    to_mid();
    chk("clr_empty_n", 32'(bus.EMPTY_N), 32'h0);
    chk("clr_ptr_kept", 32'(bus.REQ_GRANT), 32'b1000);
    to_next();
    bus.REQ_VALID = 4'b0001;
    to_mid();
    chk("clr_id", 32'(bus.D_OUT_ID), 32'h3);
    chk("clr_dout", 32'(bus.D_OUT), 32'hA3);
    to_next();

    // Drain, then DEQ while empty.
    bus.REQ_VALID = 4'b0000;
    to_next();
    to_mid();
    chk("ed_empty_n", 32'(bus.EMPTY_N), 32'h0);
    to_next();
    to_mid();
    chk("ed_empty_n2", 32'(bus.EMPTY_N), 32'h0);
    chk("ed_stale_dout", 32'(bus.D_OUT), 32'hA0);
    chk("ed_stale_id", 32'(bus.D_OUT_ID), 32'h0);
    bus.DEQ       = 1'b0;
    bus.REQ_VALID = 4'b1111;
    #1;
    chk("ed_ptr_grant", 32'(bus.REQ_GRANT), 32'b0010);
    to_next();

    // Randomized traffic; producers hold offers until granted.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.REQ_VALID[i] || m_g[i]) begin
          bus.REQ_VALID[i]        = 1'($urandom_range(0, 1));
          bus.REQ_DATA[i*W +: W]  = 8'($urandom);
        end
      end
      bus.DEQ = m_full ? ($urandom_range(0, 3) != 0) : 1'b0;
      bus.CLR = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 49) == 0);
      to_next();
    end

    rst           = 1'b0;
    bus.CLR       = 1'b0;
    bus.DEQ       = 1'b0;
    bus.REQ_VALID = '0;
    to_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo1_rr_arbiter.md
Name: fifo1_rr_arbiter

Overview:
- Shares a single depth-1 FIFO stage between n_req independent producers.
- Round-robin arbitration grants at most one producer per cycle into the one-entry holding register.
- The consumer sees a standard EMPTY_N/D_OUT/DEQ interface, plus the winning producer's index.
- Sits in front of any single-consumer sink (bus master port, shared pipe) that several rules or requesters must feed.

Parameters:
- n_req, 4, number of requesters; legal range 2..16.
- width, 8, payload width in bits.
- guarded, 1, when 1, simulation warns on DEQ while empty; when 0, the warning is suppressed.
- idw (localparam), clog2(n_req), width of the source ID.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  reset, synchronous, active-high.
- REQ_VALID  in  n_req  bit i: producer i offers data this cycle.
- REQ_DATA  in  n_req*width  producer i payload in bits [i*width +: width].
- REQ_GRANT  out  n_req  one-hot or zero, combinational; bit i: producer i accepted this cycle.
- CLR  in  1  flush the held entry.
- DEQ  in  1  consumer takes the entry.
- EMPTY_N  out  1  entry valid, registered.
- D_OUT  out  width  held payload, registered.
- D_OUT_ID  out  idw  index of the producer that supplied D_OUT, registered.

Behaviour:
- State:
  - full (1b)
  - ptr (idw b), the highest-priority index
  - data_reg
  - id_reg
- EMPTY_N = full.
- Reset (RST=1 at posedge): full=0, ptr=0, data_reg=0, id_reg=0. REQ_GRANT is forced to 0 while RST=1.
- Reset applied mid-transfer drops any held entry without a handshake; producers must re-offer.
- accept_ok = !full || DEQ. Enqueue in the same cycle as a dequeue is legal (full throughput, 1 item/cycle).
- Grant, combinational:
  - If accept_ok && !CLR && !RST, the winner w is the first i with REQ_VALID[i]=1, scanning ptr, ptr+1, ..., wrapping modulo n_req.
  - REQ_GRANT = onehot(w). If no request is valid, REQ_GRANT = 0.
  - No combinational path from REQ_VALID/REQ_DATA to D_OUT, D_OUT_ID or EMPTY_N.
- On grant (posedge): data_reg<=REQ_DATA[w], id_reg<=w, full<=1, ptr<=(w+1) mod n_req.
  - Wrap: if w = n_req-1, then ptr<=0.
- On DEQ without grant: full<=0. data_reg and id_reg are held (stale, not cleared).
- DEQ while empty: no state change. If guarded=1, simulation displays "fifo1_rr_arbiter: DEQ on empty" (translate_off).
- CLR (priority below RST, above everything else):
  - full<=0; no grant in that cycle.
  - ptr unchanged; DEQ ignored.
- Latency: a granted producer's data appears on D_OUT with EMPTY_N=1 in the cycle after the grant.
- Fairness: a continuously requesting producer is granted within n_req accepted transfers.
- ptr advances only on a grant. Idle cycles and blocked cycles (full && !DEQ) do not move it.
- Producers must hold REQ_VALID and REQ_DATA stable until granted. The block does not check this.

Decomposition:
- Shared package fifo_arb_pkg:
  - function clog2
  - function rr_pick(req, ptr), returning the winner index and a found flag
- One natural sub-module: rr_pick_n, a pure combinational rotating priority encoder (req, ptr -> onehot, idx, any). It is reusable by other arbiters.
- The holding register stays inline; it is not instantiated as a separate FIFO.

Test Plan:
- Reset check: RST=1 for 2 cycles with REQ_VALID=4'b1111 -> REQ_GRANT=0 throughout; after RST=0, EMPTY_N=0 and ptr=0. The first grant in the next cycle is 4'b0001.
- Round-robin rotation: all four producers valid continuously, DEQ=1 every cycle, n_req=4, data_i=8'hA0+i -> grants 0,1,2,3,0,... The D_OUT sequence is A0,A1,A2,A3,A0 with D_OUT_ID 0,1,2,3,0, and EMPTY_N stays 1 after the first cycle.
- Backpressure: full with DEQ=0 and REQ_VALID=4'b0110 -> REQ_GRANT=0, D_OUT held, ptr unchanged. On DEQ=1, the grant goes to producer 1 in the same cycle, and D_OUT_ID=1 the next cycle.
- Wrap and skip: ptr=3 with REQ_VALID=4'b0101 -> grant 0 (index 3 is not valid, so the scan wraps to 0); next ptr=1. The following grant, with the same request vector, goes to 2.
- CLR: full, CLR=1 with DEQ=1 and REQ_VALID=4'b1000 -> REQ_GRANT=0, next EMPTY_N=0, ptr unchanged. The next cycle grants producer 3.
- Empty DEQ: EMPTY_N=0, DEQ=1, no requests -> state unchanged and one warning printed (guarded=1). With guarded=0, no message is printed.
